// File: rtl/console_rx.sv
// rtl/console_rx.sv - 8N1 serial console receiver with show-ahead byte FIFO
module console_rx #(
    parameter int CLK_DIV = 16,
    parameter int FIFO_AW = 2
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       rxd,
    output logic [7:0] cd,
    output logic       crda,
    input  logic       cack,
    output logic       frame_err,
    output logic       overrun
);

    localparam int CW    = $clog2(CLK_DIV);
    localparam int DEPTH = 1 << FIFO_AW;
    localparam logic [CW-1:0] HALF_LOAD = CW'(CLK_DIV / 2 - 1);
    localparam logic [CW-1:0] BIT_LOAD  = CW'(CLK_DIV - 1);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_START = 2'd1;
    localparam logic [1:0] S_DATA  = 2'd2;
    localparam logic [1:0] S_STOP  = 2'd3;

    logic              rx_meta;
    logic              rxs;
    logic [1:0]        state;
    logic [CW-1:0]     cnt;
    logic [2:0]        bit_idx;
    logic [7:0]        shreg;

    logic [7:0]        mem [DEPTH];
    logic [FIFO_AW-1:0] wp;
    logic [FIFO_AW-1:0] rp;
    logic [FIFO_AW:0]   count;
    logic [FIFO_AW:0]   count_next;

    logic stop_edge;
    logic push;
    logic bad_stop;
    logic full;
    logic pop;
    logic wr_en;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rx_meta <= 1'b1;
            rxs     <= 1'b1;
        end else begin
            rx_meta <= rxd;
            rxs     <= rx_meta;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state   <= S_IDLE;
            cnt     <= '0;
            bit_idx <= '0;
            shreg   <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (!rxs) begin
                        state <= S_START;
                        cnt   <= HALF_LOAD;
                    end
                end
                S_START: begin
                    if (cnt == '0) begin
                        // A start bit that is high again at mid-bit is treated as line noise
                        if (!rxs) begin
                            state   <= S_DATA;
                            cnt     <= BIT_LOAD;
                            bit_idx <= '0;
                        end else begin
                            state <= S_IDLE;
                        end
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                S_DATA: begin
                    if (cnt == '0) begin
                        shreg <= {rxs, shreg[7:1]};
                        cnt   <= BIT_LOAD;
                        if (bit_idx == 3'd7) begin
                            state <= S_STOP;
                        end else begin
                            bit_idx <= bit_idx + 1'b1;
                        end
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                default: begin
                    // Leave mid-stop-bit so a directly following start bit is not missed
                    if (cnt == '0) begin
                        state <= S_IDLE;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
            endcase
        end
    end

    assign stop_edge = (state == S_STOP) && (cnt == '0);
    assign push      = stop_edge && rxs;
    assign bad_stop  = stop_edge && !rxs;
    assign full      = (count == (FIFO_AW + 1)'(DEPTH));
    assign pop       = crda && cack;
    // A simultaneous pop frees the slot, so a full FIFO still accepts the byte
    assign wr_en     = push && (!full || pop);

    always_comb begin
        count_next = count + (FIFO_AW + 1)'(wr_en) - (FIFO_AW + 1)'(pop);
    end

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wp] <= shreg;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wp        <= '0;
            rp        <= '0;
            count     <= '0;
            crda      <= 1'b0;
            frame_err <= 1'b0;
            overrun   <= 1'b0;
        end else begin
            if (wr_en) begin
                wp <= wp + 1'b1;
            end
            if (pop) begin
                rp <= rp + 1'b1;
            end
            count     <= count_next;
            crda      <= (count_next != '0);
            frame_err <= bad_stop;
            overrun   <= push && full && !pop;
        end
    end

    assign cd = crda ? mem[rp] : 8'h00;

endmodule

// File: tb/tb_console_rx.sv
// tb/tb_console_rx.sv - scoreboard bench for console_rx
module tb_console_rx;

    localparam int CLK_DIV = 16;

    logic       clk;
    logic       reset;
    logic       rxd;
    logic [7:0] cd;
    logic       crda;
    logic       cack;
    logic       frame_err;
    logic       overrun;

    int         n_pass;
    int         n_total;
    int         fe_cnt;
    int         ov_cnt;
    logic [7:0] exp_q[$];

    console_rx #(.CLK_DIV(CLK_DIV), .FIFO_AW(2)) dut (
        .clk      (clk),
        .reset    (reset),
        .rxd      (rxd),
        .cd       (cd),
        .crda     (crda),
        .cack     (cack),
        .frame_err(frame_err),
        .overrun  (overrun)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        n_total++;
        if (act == exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Monitor: samples 1 time unit before each rising edge
    initial begin
        logic prev_flag;
        logic [7:0] e;
        prev_flag = 1'b0;
        forever begin
            @(negedge clk);
            #4;
            if (crda && cack) begin
                if (exp_q.size() == 0) begin
                    chk("sb_unexpected_pop", int'(cd), -1);
                end else begin
                    e = exp_q.pop_front();
                    chk("sb_cd", int'(cd), int'(e));
                end
            end
            if (frame_err || overrun) begin
                chk("flag_exclusive", int'(frame_err & overrun), 0);
                chk("flag_width", int'(prev_flag), 0);
            end
            if (frame_err) fe_cnt++;
            if (overrun) ov_cnt++;
            prev_flag = frame_err | overrun;
        end
    end

    task automatic send_byte(input logic [7:0] b, input logic stop_bit, input logic expect_push);
        if (expect_push) exp_q.push_back(b);
        @(negedge clk);
        rxd = 1'b0;
        repeat (CLK_DIV) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            rxd = b[i];
            repeat (CLK_DIV) @(negedge clk);
        end
        rxd = stop_bit;
        repeat (CLK_DIV) @(negedge clk);
        rxd = 1'b1;
    endtask

    task automatic pop_n(input int n);
        @(negedge clk);
        cack = 1'b1;
        repeat (n) @(negedge clk);
        cack = 1'b0;
    endtask

    task automatic sample_point();
        @(negedge clk);
        #4;
    endtask

    initial begin
        int k;
        n_pass  = 0;
        n_total = 0;
        fe_cnt  = 0;
        ov_cnt  = 0;
        reset   = 1'b0;
        rxd     = 1'b1;
        cack    = 1'b0;

        repeat (3) @(negedge clk);
        #4;
        chk("reset_crda", int'(crda), 0);
        chk("reset_cd", int'(cd), 0);
        chk("reset_flags", int'({frame_err, overrun}), 0);
        @(negedge clk);
        reset = 1'b1;
        repeat (5) @(negedge clk);

        // First byte: latency from rxd fall to crda
        k = 0;
        fork
            send_byte(8'hA5, 1'b1, 1'b1);
            begin
                @(negedge clk);
                for (int i = 0; i < 400; i++) begin
                    @(posedge clk);
                    #1;
                    k++;
                    if (crda) break;
                end
                chk("latency_cycles", k, 155);
                chk("first_cd", int'(cd), 8'hA5);
            end
        join
        pop_n(1);
        #4;
        chk("after_pop_crda", int'(crda), 0);
        chk("after_pop_cd", int'(cd), 0);

        // Fill FIFO, then overrun with a fifth byte
        send_byte(8'h01, 1'b1, 1'b1);
        send_byte(8'h80, 1'b1, 1'b1);
        send_byte(8'hFF, 1'b1, 1'b1);
        send_byte(8'h00, 1'b1, 1'b1);
        send_byte(8'h3C, 1'b1, 1'b0);
        repeat (4) @(negedge clk);
        chk("overrun_count", ov_cnt, 1);
        pop_n(4);
        #4;
        chk("drain_crda", int'(crda), 0);

        // Framing error on 0x55, then normal 0x66
        send_byte(8'h55, 1'b0, 1'b0);
        repeat (30) @(negedge clk);
        #4;
        chk("frame_err_count", fe_cnt, 1);
        chk("frame_err_crda", int'(crda), 0);
        send_byte(8'h66, 1'b1, 1'b1);
        pop_n(1);

        // Short low glitch on idle line
        @(negedge clk);
        rxd = 1'b0;
        repeat (4) @(negedge clk);
        rxd = 1'b1;
        repeat (30) @(negedge clk);
        #4;
        chk("glitch_crda", int'(crda), 0);
        chk("glitch_flags", fe_cnt + ov_cnt, 2);
        send_byte(8'h12, 1'b1, 1'b1);
        pop_n(1);

        // Full FIFO with pop on exactly the push edge of the fifth byte
        send_byte(8'h11, 1'b1, 1'b1);
        send_byte(8'h22, 1'b1, 1'b1);
        send_byte(8'h33, 1'b1, 1'b1);
        send_byte(8'h44, 1'b1, 1'b1);
        fork
            send_byte(8'h77, 1'b1, 1'b1);
            begin
                @(negedge clk);
                repeat (154) @(negedge clk);
                cack = 1'b1;
                @(negedge clk);
                cack = 1'b0;
            end
        join
        repeat (4) @(negedge clk);
        #4;
        chk("simul_overrun", ov_cnt, 1);
        chk("simul_crda", int'(crda), 1);
        pop_n(4);
        #4;
        chk("simul_drain_crda", int'(crda), 0);

        // Reset pulse in the middle of a frame
        fork
            send_byte(8'hF0, 1'b1, 1'b0);
            begin
                @(negedge clk);
                repeat (100) @(negedge clk);
                reset = 1'b0;
                #4;
                chk("midreset_crda", int'(crda), 0);
                chk("midreset_flags", int'({frame_err, overrun}), 0);
                @(negedge clk);
                reset = 1'b1;
            end
        join
        repeat (20) @(negedge clk);
        #4;
        chk("midreset_no_partial", int'(crda), 0);
        send_byte(8'h9A, 1'b1, 1'b1);
        pop_n(1);
        repeat (4) @(negedge clk);
        #4;
        chk("final_crda", int'(crda), 0);
        chk("final_fe_count", fe_cnt, 1);
        chk("final_ov_count", ov_cnt, 1);
        chk("sb_empty", exp_q.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
